// File: rtl/zoom_engine.sv
// Frame zoom engine: copy, 2x replicate, 2x decimate or 2x2 block-average into a destination frame.
// Define ZOOM_ENGINE_AVG_EN to build the block-average (mode 11) datapath; otherwise mode 11 is rejected.
module zoom_engine #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [PIX_W-1:0]  i_rd_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic              o_wr_en
);

  localparam int X_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WT_W = $clog2(RD_LAT + 1);

  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMG_H - 1);
  localparam logic [WT_W-1:0]   WAIT_LAST = WT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] A_W       = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] A_QW      = ADDR_W'(IMG_W / 4);
  localparam logic [ADDR_W-1:0] A_TW      = ADDR_W'(3 * IMG_W / 4);
  localparam logic [ADDR_W-1:0] A_QH      = ADDR_W'(IMG_H / 4);
  localparam logic [ADDR_W-1:0] A_TH      = ADDR_W'(3 * IMG_H / 4);

  localparam logic [1:0] M_COPY = 2'b00;
  localparam logic [1:0] M_ZIN  = 2'b01;
  localparam logic [1:0] M_DEC  = 2'b10;
  localparam logic [1:0] M_AVG  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [1:0]        r_mode;
  logic [X_W-1:0]    r_dx, w_tx;
  logic [Y_W-1:0]    r_dy, w_ty;
  logic [WT_W-1:0]   r_wait;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;
  logic              r_error;

  logic [1:0]        w_mode_t;
  logic [ADDR_W-1:0] w_txa, w_tya, w_sx, w_sy, w_src_addr, w_dst_addr;
  logic              w_in_win, w_need_read, w_last, w_mode_ok, w_more;
  logic              w_dispatch, w_capture, w_reject;

`ifdef ZOOM_ENGINE_AVG_EN
  logic [1:0]         r_sub;
  logic [PIX_W+1:0]   r_acc, w_sum;
  logic [ADDR_W-1:0]  r_src_base, w_sub_off;

  assign w_mode_ok = 1'b1;
  assign w_more    = (r_mode == M_AVG) && (r_sub != 2'd3);
  assign w_sum     = r_acc + (PIX_W+2)'(i_rd_data);

  // Offset of the read that follows sub-read r_sub inside the 2x2 block.
  always_comb begin
    w_sub_off = A_W + ADDR_W'(1);
    case (r_sub)
      2'd0:    w_sub_off = ADDR_W'(1);
      2'd1:    w_sub_off = A_W;
      default: w_sub_off = A_W + ADDR_W'(1);
    endcase
  end
`else
  assign w_mode_ok = (i_mode != M_AVG);
  assign w_more    = 1'b0;
`endif

  // The pixel about to be dispatched: (0,0) on start, else the raster successor.
  always_comb begin
    w_tx = '0;
    w_ty = '0;
    if (r_state == S_WRITE) begin
      if (r_dx == X_LAST) begin
        w_ty = r_dy + 1'b1;
      end else begin
        w_tx = r_dx + 1'b1;
        w_ty = r_dy;
      end
    end
  end

  assign w_last   = (r_dx == X_LAST) && (r_dy == Y_LAST);
  assign w_mode_t = (r_state == S_IDLE) ? i_mode : r_mode;
  assign w_txa    = ADDR_W'(w_tx);
  assign w_tya    = ADDR_W'(w_ty);
  assign w_in_win = (w_txa >= A_QW) && (w_txa < A_TW) && (w_tya >= A_QH) && (w_tya < A_TH);

  always_comb begin
    w_sx = w_txa;
    w_sy = w_tya;
    case (w_mode_t)
      M_ZIN: begin
        w_sx = (w_txa >> 1) + A_QW;
        w_sy = (w_tya >> 1) + A_QH;
      end
      M_DEC, M_AVG: begin
        w_sx = (w_txa - A_QW) << 1;
        w_sy = (w_tya - A_QH) << 1;
      end
      default: ;
    endcase
  end

  assign w_src_addr  = w_sy * A_W + w_sx;
  assign w_dst_addr  = w_tya * A_W + w_txa;
  assign w_need_read = (w_mode_t == M_COPY) || (w_mode_t == M_ZIN) || w_in_win;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_dispatch   = 1'b0;
    w_capture    = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_mode_ok) begin
            w_dispatch   = 1'b1;
            w_state_next = w_need_read ? S_READ : S_WRITE;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_READ: w_state_next = i_abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (r_wait == WAIT_LAST) begin
          w_capture    = 1'b1;
          w_state_next = w_more ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_dispatch   = 1'b1;
          w_state_next = w_need_read ? S_READ : S_WRITE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state == S_READ) || (r_state == S_WAIT) || (r_state == S_WRITE);
    o_wr_en = (r_state == S_WRITE);
    o_done  = (r_state == S_DONE);
  end

  assign o_error   = r_error;
  assign o_rd_addr = r_rd_addr;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mode    <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_wait    <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_error   <= 1'b0;
`ifdef ZOOM_ENGINE_AVG_EN
      r_sub      <= '0;
      r_acc      <= '0;
      r_src_base <= '0;
`endif
    end else begin
      r_error <= w_reject;
      r_wait  <= (r_state == S_WAIT) ? r_wait + 1'b1 : '0;
      if (w_dispatch) begin
        r_dx      <= w_tx;
        r_dy      <= w_ty;
        r_wr_addr <= w_dst_addr;
        r_wr_data <= '0;
        if (r_state == S_IDLE) r_mode <= i_mode;
        if (w_need_read) r_rd_addr <= w_src_addr;
`ifdef ZOOM_ENGINE_AVG_EN
        r_src_base <= w_src_addr;
        r_sub      <= '0;
        r_acc      <= '0;
`endif
      end else if (w_capture) begin
`ifdef ZOOM_ENGINE_AVG_EN
        if (r_mode == M_AVG) begin
          r_acc <= w_sum;
          if (r_sub == 2'd3) begin
            r_wr_data <= PIX_W'(w_sum >> 2);
          end else begin
            r_sub     <= r_sub + 1'b1;
            r_rd_addr <= r_src_base + w_sub_off;
          end
        end else begin
          r_wr_data <= i_rd_data;
        end
`else
        r_wr_data <= i_rd_data;
`endif
      end
`ifdef ZOOM_ENGINE_AVG_EN
      // A partial 2x2 sum never survives a return to IDLE (abort or completion).
      else if (w_state_next == S_IDLE) begin
        r_sub <= '0;
        r_acc <= '0;
      end
`endif
    end
  end

endmodule

// File: doc/zoom_engine.md
ZOOM_ENGINE -- requirements
Module: zoom_engine

Interface
REQ-001 Parameter IMG_W, default 320, frame width in pixels; SHALL be a multiple of 4.
REQ-002 Parameter IMG_H, default 240, frame height in pixels; SHALL be a multiple of 4.
REQ-003 Parameter ADDR_W, default 17, pixel address width; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-004 Parameter PIX_W, default 8, pixel width.
REQ-005 Parameter RD_LAT, default 2, source memory read latency in cycles; SHALL be at least 1.
REQ-006 clock  in  1  sole clock; all logic on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request; sampled only in IDLE.
REQ-009 mode  in  2  operation, latched at accepted start: 00 copy, 01 zoom-in replicate 2x, 10 zoom-out decimate 2x, 11 zoom-out block-average 2x2.
REQ-010 abort  in  1  cancels the running operation.
REQ-011 busy  out  1  high from the cycle after accepted start until completion or abort.
REQ-012 done  out  1  one-cycle pulse on completion.
REQ-013 error  out  1  one-cycle pulse on a rejected start.
REQ-014 rd_addr  out  ADDR_W  source read address.
REQ-015 rd_data  in  PIX_W  source data, valid RD_LAT cycles after rd_addr.
REQ-016 wr_addr / wr_data / wr_en  out  ADDR_W / PIX_W / 1  destination write port.

Function
REQ-017 The engine SHALL produce destination pixels (dx,dy) in raster order, dx fastest; address = dy*IMG_W+dx.
REQ-018 States: IDLE, READ, WAIT, WRITE, DONE. READ drives rd_addr for 1 cycle; WAIT lasts RD_LAT cycles and then captures rd_data; WRITE asserts wr_en for exactly 1 cycle.
REQ-019 Copy: source = (dx,dy); cost = RD_LAT+2 cycles per pixel.
REQ-020 Zoom-in: source = (dx/2 + IMG_W/4, dy/2 + IMG_H/4), i.e. the central quarter is magnified 2x.
REQ-021 Decimate: for dx in [IMG_W/4, 3*IMG_W/4) and dy in [IMG_H/4, 3*IMG_H/4), source = (2*(dx-IMG_W/4), 2*(dy-IMG_H/4)); other pixels SHALL be written 0 with no read, at 1 cycle per pixel.
REQ-022 Average: same window as REQ-021; 4 sequential reads in order (sx,sy), (sx+1,sy), (sx,sy+1), (sx+1,sy+1); sum in PIX_W+2 bits; written value = sum>>2, truncating.
REQ-023 At most one read SHALL be outstanding; rd_addr SHALL hold its value outside READ.
REQ-024 The DONE state SHALL follow the WRITE of pixel (IMG_W-1, IMG_H-1); done=1 and busy=0 in the same cycle; then IDLE.
REQ-025 start while busy SHALL be ignored and SHALL NOT restart the operation.
REQ-026 abort while busy: next cycle IDLE, busy=0, wr_en=0, no done; abort in IDLE has no effect; abort and start in the same IDLE cycle: start wins.
REQ-027 A partially accumulated average SHALL be discarded on abort or reset.

Reset
REQ-028 When reset is asserted: state IDLE; busy, done, error, wr_en = 0; rd_addr, wr_addr, wr_data = 0; counters and accumulator = 0.
REQ-029 Reset mid-operation SHALL produce no further writes; a new start SHALL be accepted in the first cycle after reset deasserts.

Configuration
REQ-030 Macro ZOOM_ENGINE_AVG_EN defined: mode 11 performs REQ-022.
REQ-031 Macro absent: no accumulator logic; start with mode 11 SHALL pulse error for 1 cycle, busy stays 0, the engine stays in IDLE, and no read or write occurs.

Verification (IMG_W=8, IMG_H=4, RD_LAT=2 unless stated)
REQ-032 Copy with src[i]=i -> 32 writes, wr_addr 0..31, wr_data=i; done 128 cycles after busy rises; done high for exactly 1 cycle.
REQ-033 Zoom-in with src[i]=i -> dest(0,0)=src(2,1)=10, dest(1,0)=10, dest(2,0)=11, dest(7,3)=src(5,2)=21.
REQ-034 Decimate -> dest(2,1)=src(0,0), dest(3,2)=src(2,2); dest(0,0)=0 and dest(7,3)=0, each without a read.
REQ-035 Average with macro on, src(0..1,0..1)={10,11,18,20} -> dest(2,1)=14; with macro off, mode 11 -> error pulse, no wr_en.
REQ-036 Abort asserted at the 5th write of a copy -> no further wr_en, busy low next cycle, no done; a following start completes normally.
REQ-037 Asynchronous reset pulse mid-WAIT -> all outputs 0 immediately; start in the first cycle after reset is accepted.
